// File: rtl/ppu_pkg.sv
// Shared definitions for the post-processing unit.
//   - Mode encodings carried on i_mode (value 3 behaves like PPU_MODE_RELU).
//   - Sequencer state encoding used by ppu_vec.
package ppu_pkg;

  localparam logic [1:0] PPU_MODE_BYPASS  = 2'd0;
  localparam logic [1:0] PPU_MODE_REQUANT = 2'd1;
  localparam logic [1:0] PPU_MODE_RELU    = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PROC,
    ST_EMIT,
    ST_DONE
  } ppu_state_e;

endpackage

// File: rtl/ppu_requant_lane.sv
// One lane of requantisation, purely combinational.
//   acc_i    : signed accumulator value
//   scale_i  : signed multiplier
//   shift_i  : unsigned rounding right-shift amount
//   bypass_i : saturate acc_i directly, ignoring scale and shift
//   relu_i   : clamp negative results to zero
//   res_o    : signed saturated result
module ppu_requant_lane #(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned MUL_W   = 16,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned OUT_W   = 8
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [MUL_W-1:0]   scale_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               bypass_i,
  input  logic               relu_i,
  output logic [OUT_W-1:0]   res_o
);

  // One guard bit above the full product so the rounding add cannot overflow.
  localparam int unsigned PX_W = ACC_W + MUL_W + 1;

  localparam logic signed [PX_W-1:0] SAT_MAX =
    {{(PX_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PX_W-1:0] SAT_MIN =
    {{(PX_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [PX_W-1:0] acc_x;
  logic signed [PX_W-1:0] scale_x;
  logic signed [PX_W-1:0] prod;
  logic        [PX_W-1:0] rnd;
  logic signed [PX_W-1:0] scaled;
  logic signed [PX_W-1:0] pre_sat;
  logic        [OUT_W-1:0] sat;

  always_comb begin
    acc_x   = {{(PX_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    scale_x = {{(PX_W-MUL_W){scale_i[MUL_W-1]}}, scale_i};
    prod    = acc_x * scale_x;
    // Half-LSB rounding term; collapses to zero when shift_i is zero.
    rnd     = (PX_W'(1) << shift_i) >> 1;
    scaled  = (prod + $signed(rnd)) >>> shift_i;
    pre_sat = bypass_i ? acc_x : scaled;

    if (pre_sat > SAT_MAX) begin
      sat = SAT_MAX[OUT_W-1:0];
    end else if (pre_sat < SAT_MIN) begin
      sat = SAT_MIN[OUT_W-1:0];
    end else begin
      sat = pre_sat[OUT_W-1:0];
    end

    res_o = (relu_i && sat[OUT_W-1]) ? '0 : sat;
  end

endmodule

// File: rtl/ppu_vec.sv
// Vector post-processing unit: accepts LANES signed accumulators per
// valid/ready handshake, requantises each lane, packs PACK results per RAM
// word and writes WORDS = LANES/PACK words to sequential, wrapping addresses.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : run start (IDLE only), latches mode/scale/shift/base/count
//   i_mode           : 0 bypass, 1 requant, 2/3 requant + ReLU
//   i_scale, i_shift : requant multiplier and rounding shift
//   i_base_addr      : first write address of the run
//   i_num_vec        : vectors in the run (0 goes straight to DONE)
//   i_acc_valid, o_acc_ready, i_acc_data : accumulator vector handshake
//   o_ram_we, o_ram_addr, o_ram_data     : RAM write port
//   o_busy, o_done   : run in progress, one-cycle end-of-run pulse
module ppu_vec
  import ppu_pkg::*;
#(
  parameter int unsigned LANES   = 16,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned PACK    = 4,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned MUL_W   = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [1:0]               i_mode,
  input  logic [MUL_W-1:0]         i_scale,
  input  logic [SHIFT_W-1:0]       i_shift,
  input  logic [ADDR_W-1:0]        i_base_addr,
  input  logic [ADDR_W-1:0]        i_num_vec,
  input  logic                     i_acc_valid,
  output logic                     o_acc_ready,
  input  logic [LANES*ACC_W-1:0]   i_acc_data,
  output logic                     o_ram_we,
  output logic [ADDR_W-1:0]        o_ram_addr,
  output logic [PACK*OUT_W-1:0]    o_ram_data,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned WORDS     = LANES / PACK;
  localparam int unsigned WORD_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned WORD_BITS = PACK * OUT_W;

  ppu_state_e state_q, state_d;

  logic [1:0]             mode_q;
  logic [MUL_W-1:0]       scale_q;
  logic [SHIFT_W-1:0]     shift_q;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      vec_left_q, vec_left_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [LANES*ACC_W-1:0] acc_q;
  logic [WORD_BITS-1:0]   res_q [WORDS];
  logic [WORD_BITS-1:0]   data_q, data_d;
  logic                   we_q, busy_q, done_q, ready_q;

  logic [OUT_W-1:0]       lane_res  [LANES];
  logic [WORD_BITS-1:0]   lane_word [WORDS];
  logic                   bypass, relu_en, hs, start_ok, last_word;

  assign bypass    = (mode_q == PPU_MODE_BYPASS);
  assign relu_en   = (mode_q >= PPU_MODE_RELU);
  // ready_q is high exactly while the state register holds WAIT.
  assign hs        = ready_q && i_acc_valid;
  assign start_ok  = (state_q == ST_IDLE) && i_start;
  assign last_word = (word_q == WORD_W'(WORDS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ppu_requant_lane #(
      .ACC_W   (ACC_W),
      .MUL_W   (MUL_W),
      .SHIFT_W (SHIFT_W),
      .OUT_W   (OUT_W)
    ) u_lane (
      .acc_i    (acc_q[l*ACC_W +: ACC_W]),
      .scale_i  (scale_q),
      .shift_i  (shift_q),
      .bypass_i (bypass),
      .relu_i   (relu_en),
      .res_o    (lane_res[l])
    );
  end

  always_comb begin
    lane_word = '{default: '0};
    for (int unsigned k = 0; k < WORDS; k++) begin
      for (int unsigned j = 0; j < PACK; j++) begin
        lane_word[k][j*OUT_W +: OUT_W] = lane_res[k*PACK + j];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    vec_left_d = vec_left_q;
    word_d     = word_q;
    data_d     = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d     = i_base_addr;
          vec_left_d = i_num_vec;
          state_d    = (i_num_vec == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (hs) begin
          vec_left_d = vec_left_q - ADDR_W'(1);
          state_d    = ST_PROC;
        end
      end
      ST_PROC: begin
        // Word 0 is taken straight from the lane outputs so the first write
        // lands in the cycle the result buffer is loaded.
        word_d  = '0;
        data_d  = lane_word[0];
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_word) begin
          state_d = (vec_left_q == '0) ? ST_DONE : ST_WAIT;
        end else begin
          word_d = word_q + WORD_W'(1);
          data_d = res_q[word_q + WORD_W'(1)];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      scale_q    <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      vec_left_q <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      for (int unsigned k = 0; k < WORDS; k++) begin
        res_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vec_left_q <= vec_left_d;
      word_q     <= word_d;
      data_q     <= data_d;
      if (start_ok) begin
        mode_q  <= i_mode;
        scale_q <= i_scale;
        shift_q <= i_shift;
      end
      if (hs) begin
        acc_q <= i_acc_data;
      end
      if (state_q == ST_PROC) begin
        for (int unsigned k = 0; k < WORDS; k++) begin
          res_q[k] <= lane_word[k];
        end
      end
      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      we_q    <= (state_d == ST_EMIT);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      ready_q <= (state_d == ST_WAIT);
    end
  end

  assign o_acc_ready = ready_q;
  assign o_ram_we    = we_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_data  = data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_ppu_vec.sv
// Scoreboard bench for ppu_vec: the driver pushes expected writes, ready
// cycles and done cycles as it issues stimulus; a negedge monitor pops and
// compares whatever the DUT presents.
module tb_ppu_vec;

  localparam int LANES   = 16;
  localparam int ACC_W   = 24;
  localparam int OUT_W   = 8;
  localparam int PACK    = 4;
  localparam int ADDR_W  = 13;
  localparam int MUL_W   = 16;
  localparam int SHIFT_W = 5;
  localparam int WORDS   = LANES / PACK;
  localparam int WBITS   = PACK * OUT_W;
  localparam int VBITS   = LANES * ACC_W;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic [1:0]         i_mode = '0;
  logic [MUL_W-1:0]   i_scale = '0;
  logic [SHIFT_W-1:0] i_shift = '0;
  logic [ADDR_W-1:0]  i_base_addr = '0;
  logic [ADDR_W-1:0]  i_num_vec = '0;
  logic               i_acc_valid = 1'b0;
  logic               o_acc_ready;
  logic [VBITS-1:0]   i_acc_data = '0;
  logic               o_ram_we;
  logic [ADDR_W-1:0]  o_ram_addr;
  logic [WBITS-1:0]   o_ram_data;
  logic               o_busy;
  logic               o_done;

  ppu_vec #(
    .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .PACK(PACK),
    .ADDR_W(ADDR_W), .MUL_W(MUL_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_scale(i_scale), .i_shift(i_shift), .i_base_addr(i_base_addr),
    .i_num_vec(i_num_vec), .i_acc_valid(i_acc_valid), .o_acc_ready(o_acc_ready),
    .i_acc_data(i_acc_data), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_data(o_ram_data), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [WBITS-1:0]  data;
  } wr_t;

  wr_t              wr_q[$];
  int               done_q[$];
  int               rdy_q[$];
  logic [VBITS-1:0] vec_q[$];
  int               n_checks = 0;
  int               n_pass = 0;
  bit               mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference lane: plain integer arithmetic straight from the requant rules.
  function automatic logic [OUT_W-1:0] ref_lane(input longint acc, input int mode,
                                                 input longint scale, input int shift);
    longint v;
    if (mode == 0) begin
      v = acc;
    end else begin
      v = acc * scale;
      if (shift > 0) v = v + (longint'(1) <<< (shift - 1));
      v = v >>> shift;
    end
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (mode >= 2 && v < 0) v = 0;
    return v[OUT_W-1:0];
  endfunction

  function automatic logic [WBITS-1:0] ref_word(input logic [VBITS-1:0] vec, input int k,
                                                input int mode, input int scale, input int shift);
    logic [WBITS-1:0]        w;
    logic signed [ACC_W-1:0] a;
    logic signed [MUL_W-1:0] s;
    s = scale[MUL_W-1:0];
    w = '0;
    for (int j = 0; j < PACK; j++) begin
      a = vec[(k*PACK + j)*ACC_W +: ACC_W];
      w[j*OUT_W +: OUT_W] = ref_lane(longint'(a), mode, longint'(s), shift);
    end
    return w;
  endfunction

  always @(negedge i_clk) begin
    wr_t e;
    if (mon_en) begin
      if (o_ram_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", o_ram_we, 0);
        end else begin
          e = wr_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", o_ram_addr, e.addr);
          check("wr_data", o_ram_data, e.data);
          check("ready_low_in_emit", o_acc_ready, 0);
        end
      end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
        check("missing_write", o_ram_we, 1);
        void'(wr_q.pop_front());
      end
      if (o_done) begin
        if (done_q.size() == 0) check("unexpected_done", o_done, 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        check("missing_done", o_done, 1);
        void'(done_q.pop_front());
      end
      if (rdy_q.size() != 0 && rdy_q[0] <= cyc) begin
        check("ready_cycle", {o_acc_ready, rdy_q[0] == cyc}, 2'b11);
        void'(rdy_q.pop_front());
      end
    end
  end

  function automatic logic [VBITS-1:0] const_vec(input int val);
    logic [VBITS-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*ACC_W +: ACC_W] = val[ACC_W-1:0];
    return v;
  endfunction

  function automatic logic [VBITS-1:0] rand_vec();
    logic [VBITS-1:0] v;
    int x;
    for (int l = 0; l < LANES; l++) begin
      if ($urandom_range(0, 3) == 0) x = int'($urandom);
      else x = int'($urandom_range(0, 8000)) - 4000;
      v[l*ACC_W +: ACC_W] = x[ACC_W-1:0];
    end
    return v;
  endfunction

  // Runs one complete sequence using vec_q[0..num-1]; expects to be called
  // just after a rising edge.
  task automatic run(input int mode, input int scale, input int shift, input int base,
                     input int num, input int gap_max, input bit inject_start);
    int                s, c, g;
    bit                ok;
    logic [ADDR_W-1:0] a;
    a = base[ADDR_W-1:0];
    i_start     = 1'b1;
    i_mode      = mode[1:0];
    i_scale     = scale[MUL_W-1:0];
    i_shift     = shift[SHIFT_W-1:0];
    i_base_addr = base[ADDR_W-1:0];
    i_num_vec   = num[ADDR_W-1:0];
    s = cyc;
    if (num == 0) done_q.push_back(s + 1);
    else rdy_q.push_back(s + 1);
    @(posedge i_clk); #1;
    i_start     = 1'b0;
    // Config inputs are scrambled mid-run; the latched values must hold.
    i_mode      = 2'($urandom);
    i_scale     = MUL_W'($urandom);
    i_shift     = SHIFT_W'($urandom);
    i_base_addr = ADDR_W'($urandom);
    i_num_vec   = ADDR_W'($urandom);
    check("busy_after_start", o_busy, 1);
    for (int v = 0; v < num; v++) begin
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
        i_acc_valid = 1'b0;
        i_acc_data  = {12{$urandom}};
        repeat (g) @(posedge i_clk);
        #1;
      end
      i_acc_valid = 1'b1;
      i_acc_data  = vec_q[v];
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge i_clk);
        if (o_acc_ready) begin
          ok = 1'b1;
          c = cyc;
        end
      end
      if (!ok) begin
        check("handshake_timeout", o_acc_ready, 1);
        i_acc_valid = 1'b0;
        return;
      end
      for (int k = 0; k < WORDS; k++) begin
        wr_q.push_back('{c + 2 + k, a, ref_word(vec_q[v], k, mode, scale, shift)});
        a = a + 1'b1;
      end
      if (v == num - 1) done_q.push_back(c + 2 + WORDS);
      else rdy_q.push_back(c + 2 + WORDS);
      @(posedge i_clk); #1;
      if (inject_start && v == 0) begin
        i_start     = 1'b1;
        i_num_vec   = '0;
        i_base_addr = ADDR_W'($urandom);
        @(posedge i_clk); #1;
        i_start = 1'b0;
      end
    end
    i_acc_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge i_clk);
      if (wr_q.size() == 0 && done_q.size() == 0) ok = 1'b1;
    end
    check("run_drained", ok, 1);
    @(negedge i_clk);
    check("busy_low_after_done", o_busy, 0);
    @(posedge i_clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},    o_ram_we, 0);
    check({tag, "_addr"},  o_ram_addr, 0);
    check({tag, "_data"},  o_ram_data, 0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_done"},  o_done, 0);
    check({tag, "_ready"}, o_acc_ready, 0);
  endtask

  task automatic reset_during_emit();
    int                s, c;
    bit                ok;
    logic [VBITS-1:0]  v;
    v = rand_vec();
    i_start = 1'b1; i_mode = 2'd1; i_scale = 16'd7; i_shift = 5'd3;
    i_base_addr = 13'd100; i_num_vec = 13'd1;
    s = cyc;
    rdy_q.push_back(s + 1);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_acc_valid = 1'b1;
    i_acc_data = v;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge i_clk);
      if (o_acc_ready) begin ok = 1'b1; c = cyc; end
    end
    check("rst_handshake", ok, 1);
    wr_q.push_back('{c + 2, 13'd100, ref_word(v, 0, 1, 7, 3)});
    wr_q.push_back('{c + 3, 13'd101, ref_word(v, 1, 1, 7, 3)});
    @(posedge i_clk); #1;
    i_acc_valid = 1'b0;
    while (cyc < c + 3) @(negedge i_clk);
    #1;
    mon_en = 1'b0;
    wr_q.delete(); done_q.delete(); rdy_q.delete();
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    check_outputs_zero("abort");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
    check("no_resume_busy", o_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, scale, shift, base, num;
    logic [VBITS-1:0] v;

    #12;
    check_outputs_zero("reset");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge i_clk); #1;

    // All lanes 10, scale 3, shift 2 -> 8 per lane.
    vec_q.delete(); vec_q.push_back(const_vec(10));
    run(1, 3, 2, 0, 1, 0, 0);

    // Negative rounding and ReLU.
    vec_q.delete(); vec_q.push_back(const_vec(-10));
    run(1, 3, 2, 40, 1, 2, 0);
    run(2, 3, 2, 60, 1, 2, 0);
    run(3, 3, 2, 80, 1, 2, 0);

    // Saturation in bypass and unity requant.
    v = const_vec(5);
    v[0 +: ACC_W]     = 24'd1000;
    v[ACC_W +: ACC_W] = -24'sd1000;
    vec_q.delete(); vec_q.push_back(v);
    run(0, 99, 17, 200, 1, 0, 0);
    run(1, 1, 0, 300, 1, 0, 0);

    // Address wrap across two vectors.
    vec_q.delete(); vec_q.push_back(rand_vec()); vec_q.push_back(rand_vec());
    run(1, 5, 4, 8190, 2, 3, 0);

    // Empty run.
    run(1, 3, 2, 500, 0, 0, 0);

    // Start pulse while busy must be ignored.
    vec_q.delete(); for (int i = 0; i < 3; i++) vec_q.push_back(rand_vec());
    run(2, -37, 6, 1000, 3, 1, 1);

    // Randomised runs with valid gaps of 0..5 cycles.
    for (int r = 0; r < 10; r++) begin
      mode  = $urandom_range(0, 3);
      scale = int'($urandom_range(0, 600)) - 300;
      if ($urandom_range(0, 4) == 0) scale = int'($urandom_range(0, 65535)) - 32768;
      shift = $urandom_range(0, 31);
      base  = $urandom_range(0, 8191);
      num   = $urandom_range(1, 4);
      vec_q.delete();
      for (int i = 0; i < num; i++) vec_q.push_back(rand_vec());
      run(mode, scale, shift, base, num, 5, 0);
    end

    // Abort mid-EMIT, then a clean run.
    reset_during_emit();
    vec_q.delete(); vec_q.push_back(const_vec(10)); vec_q.push_back(rand_vec());
    run(1, 3, 2, 8191, 2, 1, 0);

    check("wr_queue_empty", wr_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    check("ready_queue_empty", rdy_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
